// File: rtl/i2c_uart_bridge_ctrl.sv
// I2C-to-UART bridge sequencer: buffers received I2C bytes in a FIFO and
// feeds them one at a time to the UART transmitter with an inter-byte gap.
module i2c_uart_bridge_ctrl #(
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned GAP_CYCLES = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     rx_valid,
   input  logic [7:0]               rx_data,
   input  logic                     frame_start,
   input  logic                     frame_stop,
   output logic                     rx_ack,
   input  logic                     tx_busy,
   output logic                     tx_start,
   output logic [7:0]               tx_data,
   output logic                     overflow,
   output logic                     in_frame,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     idle
);

   localparam int unsigned AW     = $clog2(DEPTH);
   localparam int unsigned GW     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int unsigned GAP_M1 = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;
   localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
   localparam logic [GW-1:0] GAP_LOAD = GAP_M1[GW-1:0];

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT_HI,
      S_WAIT_LO,
      S_GAP
   } state_t;

   state_t          state_q;
   state_t          state_d;
   logic [GW-1:0]   gap_cnt;
   logic [AW:0]     count;
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [7:0]      mem [DEPTH];
   logic            full;
   logic            pop;
   logic            accept;
   logic            drop;

   // Fullness is judged before the pop, so a pop frees the slot a
   // simultaneous push lands in (pointers are equal when full).
   assign full   = (count == FULL_CNT);
   assign accept = rx_valid & (~full | pop);
   assign drop   = rx_valid & full & ~pop;

   assign rx_ack     = ~full;
   assign fifo_count = count;
   assign idle       = (count == '0) && (state_q == S_IDLE) && !tx_busy;

   // Next-state and handshake decode; tx_start is a pure state decode so
   // reset removes it without waiting for a clock.
   always_comb begin
      state_d  = state_q;
      pop      = 1'b0;
      tx_start = 1'b0;
      case (state_q)
         S_IDLE: begin
            if ((count != '0) && !tx_busy) begin
               state_d = S_START;
               pop     = 1'b1;
            end
         end
         S_START: begin
            tx_start = 1'b1;
            state_d  = S_WAIT_HI;
         end
         S_WAIT_HI: begin
            if (tx_busy) state_d = S_WAIT_LO;
         end
         S_WAIT_LO: begin
            if (!tx_busy) state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
         end
         S_GAP: begin
            if (gap_cnt == '0) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM state register and inter-byte gap counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         gap_cnt <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_WAIT_LO && state_d == S_GAP)
            gap_cnt <= GAP_LOAD;
         else if (state_q == S_GAP && gap_cnt != '0)
            gap_cnt <= gap_cnt - GW'(1);
      end
   end

   // FIFO storage; contents need no reset since the pointers define validity.
   always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr] <= rx_data;
   end

   // FIFO pointers, occupancy and the latched transmit byte.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         tx_data <= '0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + AW'(1);
         if (pop) begin
            rd_ptr  <= rd_ptr + AW'(1);
            tx_data <= mem[rd_ptr];
         end
         case ({accept, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Sticky overflow and frame-activity flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow <= 1'b0;
         in_frame <= 1'b0;
      end else begin
         if (drop)             overflow <= 1'b1;
         else if (frame_start) overflow <= 1'b0;
         if (frame_start)      in_frame <= 1'b1;
         else if (frame_stop)  in_frame <= 1'b0;
      end
   end

endmodule

// File: doc/i2c_uart_bridge_ctrl.md
# i2c_uart_bridge_ctrl

Sequencer between the I2C slave receive path and the UART transmitter of the bridge. Bytes accepted by the I2C slave are pushed into an internal FIFO. The controller drains the FIFO one byte at a time into the UART transmitter using a start/busy handshake, with a programmable inter-byte gap. It also drives the I2C ACK decision (back-pressure) and reports overflow and activity status.

## Interface
- `DEPTH`, 8: FIFO depth in bytes; power of two, 2..64.
- `GAP_CYCLES`, 4: idle `clk` cycles inserted after each UART byte completes, before the next `tx_start`; 0 is legal.
- `clk` input 1: system clock; all logic on rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `rx_valid` input 1: one-cycle strobe; `rx_data` holds a complete received I2C data byte.
- `rx_data` input 8: received byte.
- `frame_start` input 1: one-cycle strobe on an I2C START with address match.
- `frame_stop` input 1: one-cycle strobe on an I2C STOP.
- `rx_ack` output 1: 1 = slave should ACK the next byte. Combinational: `count < DEPTH`.
- `tx_busy` input 1: UART transmitter busy.
- `tx_start` output 1: one-cycle request to the UART to send `tx_data`.
- `tx_data` output 8: byte to transmit; stable from `tx_start` until `tx_busy` falls.
- `overflow` output 1: sticky; set when a byte arrives while the FIFO is full.
- `in_frame` output 1: high between `frame_start` and `frame_stop`.
- `fifo_count` output $clog2(DEPTH)+1: current occupancy.
- `idle` output 1: FIFO empty, FSM in IDLE, and `tx_busy` low.

## Operation
- **Push**: `rx_valid` with `count < DEPTH` writes `rx_data` at `wr_ptr`, and `wr_ptr` increments modulo DEPTH. `rx_valid` with `count == DEPTH` drops the byte, sets `overflow`, and leaves `count` unchanged.
- **Pop**: occurs on the cycle the FSM leaves IDLE for START. The FIFO head is latched into `tx_data`, and `rd_ptr` increments modulo DEPTH.
- **Simultaneous push and pop**: `count` is unchanged. Both pointers advance. A push into a full FIFO in the same cycle as a pop is accepted, because fullness is evaluated before the pop. Pop when empty never occurs.
- **`overflow`**: cleared by `frame_start`. If `frame_start` and an overflowing `rx_valid` occur in the same cycle, the set wins.
- **`in_frame`**: set by `frame_start`, cleared by `frame_stop`. If both occur in the same cycle, `frame_start` wins. `frame_stop` does not flush the FIFO; queued bytes are still transmitted.
- **FSM states**: IDLE, START, WAIT_HI, WAIT_LO, GAP.
  - IDLE -> START when `count > 0` and `tx_busy == 0`. The pop happens on this transition.
  - START: `tx_start = 1` for exactly this one cycle; go to WAIT_HI.
  - WAIT_HI: wait for `tx_busy == 1`, then go to WAIT_LO.
  - WAIT_LO: wait for `tx_busy == 0`. Then go to GAP, or directly to IDLE if `GAP_CYCLES == 0`.
  - GAP: a counter loads `GAP_CYCLES - 1` on entry and decrements each cycle. Go to IDLE when the counter reaches 0.

## Timing
- **Reset values**:
  - `tx_start` = 0, `tx_data` = 8'h00
  - `overflow` = 0, `in_frame` = 0, `fifo_count` = 0
  - `rx_ack` = 1, `idle` = 1
  - FSM = IDLE; pointers and gap counter = 0
- **Reset mid-operation**: FIFO contents are discarded, and `tx_start` drops immediately (asynchronously). No partial byte is re-sent after reset.
- **Latency, empty FIFO**: a byte pushed at edge N is visible (`count = 1`) after edge N. The FSM enters START at edge N+1, so `tx_start` is high during the cycle after edge N+1. Push to `tx_start` is therefore 2 cycles.
- **Back-to-back bytes**: `tx_start` spacing is (UART busy duration) + `GAP_CYCLES` + 3 cycles (START, WAIT_HI exit, IDLE).
- **`rx_ack`**: reflects `count` after the most recent edge.
- **`fifo_count`**: registered; updates the cycle after push/pop.

## Test plan
- **Single byte**: reset, then `rx_valid` with 8'h67. Required: `fifo_count` goes to 1; `tx_start` pulses 2 cycles later with `tx_data` = 8'h67; `idle` returns high after the UART model completes plus 4 gap cycles.
- **Burst**: push 8'h67, 8'h14, 8'h1E on consecutive `rx_valid` strobes. Required: UART model receives 67, 14, 1E in order; each `tx_start` is preceded by at least 4 idle cycles after `tx_busy` falls.
- **Full/overflow**: hold `tx_busy = 1`, then push 9 bytes (DEPTH = 8). Required: `rx_ack` = 0 after the 8th byte; the 9th byte is dropped; `overflow` = 1. The next `frame_start` clears `overflow`.
- **Simultaneous push/pop at full**: FIFO full, with the FSM leaving IDLE in the same cycle a byte arrives. Required: the byte is accepted, `fifo_count` stays 8, and `overflow` stays 0.
- **Reset mid-transfer**: assert `reset` while in WAIT_LO with 3 bytes queued. Required: all outputs return to their reset values immediately, and no `tx_start` occurs after reset release until a new push.
- **Frame flags**: `frame_start` and `frame_stop` in the same cycle -> `in_frame` = 1. `frame_stop` alone -> `in_frame` = 0, and queued bytes still drain.
